nano_fetch_unit: RTL and testbench

//  Reader side of the NanoRisc program counter: consumes the registered PC value, fetches the

---
 rtl/nano_fetch_unit.sv | 214 +++++++++++++++++++++
 tb/tb_nano_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/nano_fetch_unit.sv
// nano_fetch_unit: NanoRisc fetch stage. Reads the word at the PC, hands it to decode, and writes back PC+1 or a redirect target.
// Build macro PREFETCH_BUF_EN replaces the single holding register with a 2-entry prefetch FIFO.
module nano_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               run,
  input  logic [ADDR_W-1:0]  pc_value,
  output logic               pc_write,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                pc_write_q, pc_write_d;
  logic [ADDR_W-1:0]   pc_next_q, pc_next_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic [ADDR_W-1:0]   fwd_pc_s;

  assign pc_write    = pc_write_q;
  assign pc_next     = pc_next_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

  // The PC register lags its write strobe by a cycle, so forward the value being written.
  assign fwd_pc_s = pc_write_q ? pc_next_q : pc_value;

`ifdef PREFETCH_BUF_EN
  logic [INSTR_W-1:0]  spare_q, spare_d;
  logic                spare_valid_q, spare_valid_d;
  logic                pop_s, push_s, free_s;

  assign pop_s  = instr_valid_q & instr_ready;
  assign push_s = (state_q == FETCH) & mem_req_q & mem_ack;
  assign free_s = ~(instr_valid_q & spare_valid_q & ~pop_s);

  // Next-state logic: FIFO head in instr_q, second entry in spare_q
  always_comb begin
    state_d       = state_q;
    mem_req_d     = 1'b0;
    mem_addr_d    = mem_addr_q;
    pc_write_d    = 1'b0;
    pc_next_d     = pc_next_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    spare_d       = spare_q;
    spare_valid_d = spare_valid_q;
    if (redirect) begin
      pc_write_d    = 1'b1;
      pc_next_d     = redirect_addr;
      instr_valid_d = 1'b0;
      spare_valid_d = 1'b0;
      state_d       = run ? FETCH : IDLE;
    end else begin
      if (pop_s) begin
        if (spare_valid_q) begin
          instr_d       = spare_q;
          spare_d       = mem_rdata;
          spare_valid_d = push_s;
        end else if (push_s) begin
          instr_d = mem_rdata;
        end else begin
          instr_valid_d = 1'b0;
        end
      end else if (push_s) begin
        if (instr_valid_q) begin
          spare_d       = mem_rdata;
          spare_valid_d = 1'b1;
        end else begin
          instr_d       = mem_rdata;
          instr_valid_d = 1'b1;
        end
      end else begin
        instr_valid_d = instr_valid_q;
      end
      case (state_q)
        IDLE: begin
          if (run && free_s) begin
            state_d    = FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = fwd_pc_s;
          end else begin
            state_d = IDLE;
          end
        end
        FETCH: begin
          if (mem_req_q) begin
            if (mem_ack) begin
              pc_write_d = 1'b1;
              pc_next_d  = mem_addr_q + ADDR_W'(1);
            end else begin
              mem_req_d = 1'b1;
            end
          end else if (!run) begin
            state_d = IDLE;
          end else if (free_s) begin
            mem_req_d  = 1'b1;
            mem_addr_d = fwd_pc_s;
          end else begin
            mem_req_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Second FIFO entry
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      spare_q       <= {INSTR_W{1'b0}};
      spare_valid_q <= 1'b0;
    end else begin
      spare_q       <= spare_d;
      spare_valid_q <= spare_valid_d;
    end
  end
`else
  // Next-state logic: one word outstanding, held in instr_q until decode takes it
  always_comb begin
    state_d       = state_q;
    mem_req_d     = 1'b0;
    mem_addr_d    = mem_addr_q;
    pc_write_d    = 1'b0;
    pc_next_d     = pc_next_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    if (redirect) begin
      pc_write_d    = 1'b1;
      pc_next_d     = redirect_addr;
      instr_valid_d = 1'b0;
      state_d       = run ? FETCH : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            state_d    = FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = fwd_pc_s;
          end else begin
            state_d = IDLE;
          end
        end
        FETCH: begin
          if (mem_req_q && mem_ack) begin
            instr_d       = mem_rdata;
            instr_valid_d = 1'b1;
            pc_write_d    = 1'b1;
            pc_next_d     = mem_addr_q + ADDR_W'(1);
            state_d       = HOLD;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = mem_req_q ? mem_addr_q : fwd_pc_s;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid_d = 1'b0;
            if (run) begin
              state_d    = FETCH;
              mem_req_d  = 1'b1;
              mem_addr_d = fwd_pc_s;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = HOLD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
`endif

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= {ADDR_W{1'b0}};
      pc_write_q    <= 1'b0;
      pc_next_q     <= {ADDR_W{1'b0}};
      instr_q       <= {INSTR_W{1'b0}};
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      pc_write_q    <= pc_write_d;
      pc_next_q     <= pc_next_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

endmodule

// File: tb/tb_nano_fetch_unit.sv
// Directed bench for nano_fetch_unit: expected events go into queues, a negedge monitor pops and compares.
module tb_nano_fetch_unit;
  localparam int S_PCW = 0, S_PCN = 1, S_REQ = 2, S_ADDR = 3, S_INSTR = 4, S_VALID = 5;

  logic       clock = 1'b0;
  logic       reset_n, run, pc_write, mem_req, mem_ack, redirect, instr_valid, instr_ready;
  logic [7:0] pc_value, pc_next, mem_addr, mem_rdata, redirect_addr, instr;
  logic       pc_load_en;
  logic [7:0] pc_load_val;
  logic [7:0] pc_reg = 8'h00;

  typedef struct { int sig; logic [7:0] exp; } snap_t;
  snap_t      snap_q[$];
  logic [7:0] exp_pcw_q[$];
  logic [7:0] exp_instr_q[$];
  logic [7:0] exp_addr_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  bit         done = 1'b0;
  bit         mon_done = 1'b0;

  nano_fetch_unit #(.ADDR_W(8), .INSTR_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .pc_value(pc_value),
    .pc_write(pc_write), .pc_next(pc_next), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .redirect(redirect),
    .redirect_addr(redirect_addr), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  always #5 clock = ~clock;

  // ProgramCounter stand-in: loads pc_next on pc_write, or a bench preset value.
  always @(posedge clock) begin
    if (pc_write) pc_reg <= pc_next;
    else if (pc_load_en) pc_reg <= pc_load_val;
  end
  assign pc_value = pc_reg;

  function automatic logic [7:0] dut_val(input int sig);
    case (sig)
      S_PCW:   return {7'd0, pc_write};
      S_PCN:   return pc_next;
      S_REQ:   return {7'd0, mem_req};
      S_ADDR:  return mem_addr;
      S_INSTR: return instr;
      default: return {7'd0, instr_valid};
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      S_PCW:   return "pc_write";
      S_PCN:   return "pc_next";
      S_REQ:   return "mem_req";
      S_ADDR:  return "mem_addr";
      S_INSTR: return "instr";
      default: return "instr_valid";
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic missing(input string name, input logic [7:0] exp);
    n_vec++;
    n_err++;
    $display("FAIL %s: event never seen, expected %h", name, exp);
  endtask

  // Monitor: snapshots and event-driven scoreboard checks at every falling edge.
  initial begin : monitor
    logic prev_req;
    snap_t s;
    prev_req = 1'b0;
    forever begin
      @(negedge clock);
      while (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        check(sig_name(s.sig), dut_val(s.sig), s.exp);
      end
      if (reset_n) begin
        if (pc_write) begin
          if (exp_pcw_q.size() == 0) missing("pc_write unexpected, pc_next", pc_next);
          else check("pc_next", pc_next, exp_pcw_q.pop_front());
        end
        if (instr_valid && instr_ready) begin
          if (exp_instr_q.size() == 0) missing("handoff unexpected, instr", instr);
          else check("instr handoff", instr, exp_instr_q.pop_front());
        end
        if (mem_req && !prev_req) begin
          if (exp_addr_q.size() == 0) missing("request unexpected, mem_addr", mem_addr);
          else check("mem_addr", mem_addr, exp_addr_q.pop_front());
        end
      end
      prev_req = mem_req;
      if (done && !mon_done) begin
        while (exp_pcw_q.size() > 0) missing("pc_write", exp_pcw_q.pop_front());
        while (exp_instr_q.size() > 0) missing("handoff", exp_instr_q.pop_front());
        while (exp_addr_q.size() > 0) missing("request", exp_addr_q.pop_front());
        mon_done = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic snap(input int sig, input logic [7:0] e);
    snap_t s;
    s.sig = sig;
    s.exp = e;
    snap_q.push_back(s);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mem_req && n < 20) begin
      cyc();
      n++;
    end
    if (!mem_req) snap(S_REQ, 8'h01);
  endtask

  task automatic fetch(input logic [7:0] data, input int delay);
    wait_req();
    repeat (delay) cyc();
    mem_ack   = 1'b1;
    mem_rdata = data;
    cyc();
    mem_ack   = 1'b0;
  endtask

  initial begin : stimulus
    int n;
    reset_n = 1'b0; run = 1'b1; mem_ack = 1'b1; mem_rdata = 8'hEE;
    redirect = 1'b0; redirect_addr = 8'h00; instr_ready = 1'b1;
    pc_load_en = 1'b1; pc_load_val = 8'h05;
    repeat (2) cyc();
    // reset holds everything at zero even with run and ack asserted
    for (int i = 0; i < 6; i++) snap(i, 8'h00);
    cyc();
    snap(S_PCW, 8'h00);
    mem_ack = 1'b0; run = 1'b0; pc_load_en = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();

    // basic fetch at 8'h05
    exp_addr_q.push_back(8'h05);
    exp_pcw_q.push_back(8'h06);
    exp_instr_q.push_back(8'hA3);
    exp_addr_q.push_back(8'h06);
    run = 1'b1;
    fetch(8'hA3, 2);
    snap(S_VALID, 8'h01); snap(S_INSTR, 8'hA3); snap(S_PCW, 8'h01);
    snap(S_PCN, 8'h06); snap(S_REQ, 8'h00);

    // redirect while a request is pending, then the wrap fetch at 8'hFF
    wait_req();
    redirect = 1'b1; redirect_addr = 8'hFF;
    exp_pcw_q.push_back(8'hFF);
    exp_addr_q.push_back(8'hFF);
    cyc();
    redirect = 1'b0;
    snap(S_REQ, 8'h00); snap(S_VALID, 8'h00);
    exp_pcw_q.push_back(8'h00);
    exp_instr_q.push_back(8'h11);
    instr_ready = 1'b0;
    fetch(8'h11, 1);

    // backpressure: word held, no new request
    for (int i = 0; i < 5; i++) begin
      snap(S_INSTR, 8'h11); snap(S_VALID, 8'h01); snap(S_REQ, 8'h00);
      cyc();
    end
    exp_addr_q.push_back(8'h00);
    instr_ready = 1'b1;
    cyc();

    // redirect coincident with ack: ack dropped, no PC+1 write
    wait_req();
    mem_ack = 1'b1; mem_rdata = 8'h77;
    redirect = 1'b1; redirect_addr = 8'h40;
    exp_pcw_q.push_back(8'h40);
    exp_addr_q.push_back(8'h40);
    cyc();
    mem_ack = 1'b0; redirect = 1'b0;
    snap(S_VALID, 8'h00); snap(S_REQ, 8'h00);

    // run=0 in HOLD: handoff, then idle until run returns
    exp_pcw_q.push_back(8'h41);
    exp_instr_q.push_back(8'hC4);
    instr_ready = 1'b0;
    fetch(8'hC4, 0);
    run = 1'b0; instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      snap(S_REQ, 8'h00);
      cyc();
    end
    exp_addr_q.push_back(8'h41);
    exp_pcw_q.push_back(8'h42);
    exp_instr_q.push_back(8'h9B);
    run = 1'b1; instr_ready = 1'b1;
    fetch(8'h9B, 1);
    run = 1'b0;
    cyc();

    // back-to-back redirects while idle
    exp_pcw_q.push_back(8'h80);
    exp_pcw_q.push_back(8'h81);
    redirect = 1'b1; redirect_addr = 8'h80;
    cyc();
    redirect_addr = 8'h81;
    cyc();
    redirect = 1'b0;
    snap(S_REQ, 8'h00); snap(S_VALID, 8'h00);
    repeat (3) cyc();

    done = 1'b1;
    n = 0;
    while (!mon_done && n < 10) begin
      cyc();
      n++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
